blend_operand_gen: RTL and testbench
====================================

Name: blend_operand_gen

Overview:
- Producer side of the colour mixer: takes a source fragment colour and a destination framebuffer pixel, decodes per-beat OpenGL-style blend factors, and emits the four operand colours A, B, C, D.
- The downstream mixer computes (A*B)+(C*D), with A=src, B=srcFactor colour, C=dst, D=dstFactor colour.
- Sits between the fragment pipeline / framebuffer read path and the mixer.
- Valid/ready streaming, 2-stage pipeline, global stall on back-pressure.

Parameters:
- SUB_PIXEL_WIDTH, 8, bits per channel; ONE = all ones (2^W - 1).
- PIXEL_WIDTH, 4*SUB_PIXEL_WIDTH, localparam. Channel order is R at [4W-1:3W], G, B, A at [W-1:0].
- FACTOR_WIDTH, 4, width of a blend factor code.

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_last  in  1  sideband, passed through unchanged
- s_src  in  PIXEL_WIDTH  source fragment colour
- s_dst  in  PIXEL_WIDTH  destination pixel colour
- s_srcFactor  in  FACTOR_WIDTH  source blend factor code
- s_dstFactor  in  FACTOR_WIDTH  destination blend factor code
- constColor  in  PIXEL_WIDTH  blend constant, quasi-static
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_last  out  1  delayed s_last
- m_colorA  out  PIXEL_WIDTH  src
- m_colorB  out  PIXEL_WIDTH  source factor colour
- m_colorC  out  PIXEL_WIDTH  dst
- m_colorD  out  PIXEL_WIDTH  destination factor colour

Behaviour:
- Factor codes:
  - 0 ZERO, 1 ONE
  - 2 SRC_COLOR, 3 ONE_MINUS_SRC_COLOR
  - 4 DST_COLOR, 5 ONE_MINUS_DST_COLOR
  - 6 SRC_ALPHA, 7 ONE_MINUS_SRC_ALPHA
  - 8 DST_ALPHA, 9 ONE_MINUS_DST_ALPHA
  - 10 SRC_ALPHA_SATURATE
  - 11 CONSTANT_COLOR, 12 ONE_MINUS_CONSTANT_COLOR
  - 13-15 reserved, decode as ZERO
- Factor arithmetic:
  - ONE_MINUS_x = bitwise ~x per channel, exact ONE-x, no carry.
  - *_ALPHA replicates the alpha byte into all 4 channels.
  - SRC_ALPHA_SATURATE: RGB = min(As, ~Ad), alpha = ONE.
- Stage 1: registers src, dst, last and the two factor codes.
- Stage 2: registers the decoded factor colours plus src, dst, last to the outputs.
- Latency: 2 accepted cycles from an input handshake to m_valid, assuming m_ready held high.
- Stall:
  - ce = !m_valid | m_ready.
  - s_ready = ce (combinational).
  - Both stages advance only on ce.
  - Each stage carries its own valid bit; bubbles propagate.
- Hold: while m_valid & !m_ready, all m_* outputs stay stable.
- Throughput: 1 beat/cycle with m_ready held high.
- Simultaneous events: input and output handshakes in the same cycle are both honoured; no beat is dropped or duplicated.
- constColor: sampled in stage 2. Changes are legal only while the pipe is empty.
- Reset:
  - Stage valids, m_valid and m_last clear to 0.
  - m_colorA..D clear to 0.
  - s_ready reads 1 in the cycle after reset deasserts.
  - Reset mid-stream discards in-flight beats.

Optional Feature:
- Macro BLEND_CONSTANT_COLOR_EN.
- Defined: codes 11/12 decode to constColor / ~constColor.
- Undefined: constColor is ignored (port kept, unused); codes 11/12 decode as ZERO; constant muxing logic is removed.

Decomposition:
- Package blend_pkg holds:
  - factor code localparams BLEND_ZERO..BLEND_ONE_MINUS_CONSTANT_COLOR
  - FACTOR_WIDTH
  - channel position constants
- Sub-module blend_factor_decode: combinational, (code, src, dst, constColor) -> factor colour.
  - Instantiated twice (src and dst factor) in stage 2.

Test Plan:
1. src=0x80402010, dst=0x11223344, srcFactor=SRC_ALPHA, dstFactor=ONE_MINUS_SRC_ALPHA, m_ready=1:
   - after 2 cycles A=0x80402010, B=0x10101010, C=0x11223344, D=0xEFEFEFEF.
2. srcFactor=SRC_ALPHA_SATURATE, src A=0xC0, dst A=0x30:
   - B=0xC0C0C0FF.
   - With dst A=0x80: B=0x7F7F7FFF.
3. Back-to-back 8 beats with m_ready toggling 1,0,0,1 pattern:
   - all 8 beats emerge in order, each exactly once, m_last on beat 8 only.
   - outputs stable while stalled; s_ready=0 whenever m_valid & !m_ready.
4. Codes 13,14,15:
   - B=D=0x00000000.
   - Codes 11/12 with constColor=0x0A0B0C0D: 0x0A0B0C0D / 0xF5F4F3F2 if BLEND_CONSTANT_COLOR_EN is defined, else 0.
5. Reset asserted while 2 beats in flight:
   - next cycle m_valid=0, outputs 0; no stale beat appears after reset deasserts.
6. ZERO/ONE and DST_COLOR/ONE_MINUS_DST_COLOR, dst=0x00FF7F80:
   - B=0x00000000 / 0xFFFFFFFF.
   - D=0x00FF7F80 / 0xFF0080 7F, i.e. 0xFF00807F.

Source files
------------

// File: rtl/blend_pkg.sv
// Shared constants for the blend operand generator: factor codes,
// factor code width and the channel index of each colour component.
package blend_pkg;

    localparam int FACTOR_WIDTH = 4;

    // Channel index within a pixel; channel n occupies bits [n*W +: W]
    localparam int CH_R = 3;
    localparam int CH_G = 2;
    localparam int CH_B = 1;
    localparam int CH_A = 0;

    localparam logic [FACTOR_WIDTH-1:0] BLEND_ZERO                     = 4'd0;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_ONE                      = 4'd1;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_SRC_COLOR                = 4'd2;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_ONE_MINUS_SRC_COLOR      = 4'd3;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_DST_COLOR                = 4'd4;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_ONE_MINUS_DST_COLOR      = 4'd5;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_SRC_ALPHA                = 4'd6;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_ONE_MINUS_SRC_ALPHA      = 4'd7;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_DST_ALPHA                = 4'd8;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_ONE_MINUS_DST_ALPHA      = 4'd9;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_SRC_ALPHA_SATURATE       = 4'd10;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_CONSTANT_COLOR           = 4'd11;
    localparam logic [FACTOR_WIDTH-1:0] BLEND_ONE_MINUS_CONSTANT_COLOR = 4'd12;

endpackage

// File: rtl/blend_factor_decode.sv
// Combinational blend factor decoder: turns a factor code plus the source,
// destination and constant colours into the factor colour for the mixer.
// Optional feature macro: BLEND_CONSTANT_COLOR_EN enables codes 11/12
// (constant colour and its complement); otherwise they decode as zero.
module blend_factor_decode
    import blend_pkg::*;
#(
    parameter int SUB_PIXEL_WIDTH = 8
) (
    input  logic [FACTOR_WIDTH-1:0]      code,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] src,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] dst,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] const_color,
    output logic [4*SUB_PIXEL_WIDTH-1:0] factor
);

    localparam int W = SUB_PIXEL_WIDTH;

    logic [W-1:0] src_a;
    logic [W-1:0] dst_a;
    logic [W-1:0] inv_dst_a;
    logic [W-1:0] sat;

    assign src_a     = src[CH_A*W +: W];
    assign dst_a     = dst[CH_A*W +: W];
    assign inv_dst_a = ~dst_a;
    assign sat       = (src_a < inv_dst_a) ? src_a : inv_dst_a;

`ifndef BLEND_CONSTANT_COLOR_EN
    logic unused_const;
    assign unused_const = ^const_color;
`endif

    // Select the factor colour; ONE-x is a plain bitwise complement, reserved codes give zero
    always_comb begin
        factor = '0;
        case (code)
            BLEND_ZERO:                factor = '0;
            BLEND_ONE:                 factor = '1;
            BLEND_SRC_COLOR:           factor = src;
            BLEND_ONE_MINUS_SRC_COLOR: factor = ~src;
            BLEND_DST_COLOR:           factor = dst;
            BLEND_ONE_MINUS_DST_COLOR: factor = ~dst;
            BLEND_SRC_ALPHA:           factor = {4{src_a}};
            BLEND_ONE_MINUS_SRC_ALPHA: factor = ~{4{src_a}};
            BLEND_DST_ALPHA:           factor = {4{dst_a}};
            BLEND_ONE_MINUS_DST_ALPHA: factor = ~{4{dst_a}};
            BLEND_SRC_ALPHA_SATURATE:  factor = {sat, sat, sat, {W{1'b1}}};
`ifdef BLEND_CONSTANT_COLOR_EN
            BLEND_CONSTANT_COLOR:           factor = const_color;
            BLEND_ONE_MINUS_CONSTANT_COLOR: factor = ~const_color;
`endif
            default:                   factor = '0;
        endcase
    end

endmodule

// File: rtl/blend_operand_gen.sv
// Blend operand generator: two-stage valid/ready pipeline that forwards the
// source and destination colours and decodes both blend factors so the
// downstream mixer can compute (A*B)+(C*D).
// Optional feature macro: BLEND_CONSTANT_COLOR_EN (constant colour factors).
module blend_operand_gen
    import blend_pkg::*;
#(
    parameter int SUB_PIXEL_WIDTH = 8,
    localparam int PIXEL_WIDTH = 4*SUB_PIXEL_WIDTH
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [PIXEL_WIDTH-1:0]  s_src,
    input  logic [PIXEL_WIDTH-1:0]  s_dst,
    input  logic [FACTOR_WIDTH-1:0] s_srcFactor,
    input  logic [FACTOR_WIDTH-1:0] s_dstFactor,
    input  logic [PIXEL_WIDTH-1:0]  constColor,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [PIXEL_WIDTH-1:0]  m_colorA,
    output logic [PIXEL_WIDTH-1:0]  m_colorB,
    output logic [PIXEL_WIDTH-1:0]  m_colorC,
    output logic [PIXEL_WIDTH-1:0]  m_colorD
);

    logic                    ce;
    logic                    s1_valid;
    logic                    s1_last;
    logic [PIXEL_WIDTH-1:0]  s1_src;
    logic [PIXEL_WIDTH-1:0]  s1_dst;
    logic [FACTOR_WIDTH-1:0] s1_src_factor;
    logic [FACTOR_WIDTH-1:0] s1_dst_factor;
    logic [PIXEL_WIDTH-1:0]  src_factor_color;
    logic [PIXEL_WIDTH-1:0]  dst_factor_color;

    // The whole pipe moves together; it only freezes when the output beat is stuck
    assign ce      = !m_valid || m_ready;
    assign s_ready = ce;

    blend_factor_decode #(.SUB_PIXEL_WIDTH(SUB_PIXEL_WIDTH)) u_src_decode (
        .code        (s1_src_factor),
        .src         (s1_src),
        .dst         (s1_dst),
        .const_color (constColor),
        .factor      (src_factor_color)
    );

    blend_factor_decode #(.SUB_PIXEL_WIDTH(SUB_PIXEL_WIDTH)) u_dst_decode (
        .code        (s1_dst_factor),
        .src         (s1_src),
        .dst         (s1_dst),
        .const_color (constColor),
        .factor      (dst_factor_color)
    );

    // Stage 1: capture the incoming beat and its raw factor codes
    always_ff @(posedge aclk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_src        <= '0;
            s1_dst        <= '0;
            s1_src_factor <= '0;
            s1_dst_factor <= '0;
        end else if (ce) begin
            s1_valid      <= s_valid;
            s1_last       <= s_last;
            s1_src        <= s_src;
            s1_dst        <= s_dst;
            s1_src_factor <= s_srcFactor;
            s1_dst_factor <= s_dstFactor;
        end
    end

    // Stage 2: register the four mixer operands, holding them while stalled
    always_ff @(posedge aclk) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_colorA <= '0;
            m_colorB <= '0;
            m_colorC <= '0;
            m_colorD <= '0;
        end else if (ce) begin
            m_valid  <= s1_valid;
            m_last   <= s1_last;
            m_colorA <= s1_src;
            m_colorB <= src_factor_color;
            m_colorC <= s1_dst;
            m_colorD <= dst_factor_color;
        end
    end

endmodule

// File: tb/tb_blend_operand_gen.sv
// Directed testbench for blend_operand_gen with hand-computed expected values.
// Expectations for codes 11/12 follow BLEND_CONSTANT_COLOR_EN.
module tb_blend_operand_gen;

    logic        aclk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [31:0] s_src;
    logic [31:0] s_dst;
    logic [3:0]  s_srcFactor;
    logic [3:0]  s_dstFactor;
    logic [31:0] constColor;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [31:0] m_colorA;
    logic [31:0] m_colorB;
    logic [31:0] m_colorC;
    logic [31:0] m_colorD;

    int vectorCount;
    int missCount;

    blend_operand_gen #(.SUB_PIXEL_WIDTH(8)) dut (
        .aclk        (aclk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .s_src       (s_src),
        .s_dst       (s_dst),
        .s_srcFactor (s_srcFactor),
        .s_dstFactor (s_dstFactor),
        .constColor  (constColor),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .m_colorA    (m_colorA),
        .m_colorB    (m_colorB),
        .m_colorC    (m_colorC),
        .m_colorD    (m_colorD)
    );

    // Free-running clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Push one beat through an idle pipe and check the operands two edges later
    task automatic applyStimulus(input string tag, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [3:0] sf, input logic [3:0] df,
                                 input logic [31:0] expB, input logic [31:0] expD);
        s_valid     = 1'b1;
        s_src       = src;
        s_dst       = dst;
        s_srcFactor = sf;
        s_dstFactor = df;
        s_last      = 1'b0;
        @(posedge aclk); #1;
        s_valid = 1'b0;
        @(posedge aclk); #1;
        checkOutput({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        checkOutput({tag, "_A"}, m_colorA, src);
        checkOutput({tag, "_B"}, m_colorB, expB);
        checkOutput({tag, "_C"}, m_colorC, dst);
        checkOutput({tag, "_D"}, m_colorD, expD);
    endtask

    logic [3:0]  readyPat;
    int          idxIn;
    int          idxOut;
    logic        held;
    logic [31:0] heldA;
    logic [31:0] heldB;
    logic [31:0] heldC;
    logic        heldLast;
    logic [31:0] expConst;
    logic [31:0] expConstInv;

    initial begin
        vectorCount = 0;
        missCount   = 0;
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        s_src       = '0;
        s_dst       = '0;
        s_srcFactor = '0;
        s_dstFactor = '0;
        constColor  = '0;
        m_ready     = 1'b0;

        repeat (3) @(posedge aclk);
        #1 reset = 1'b0;
        @(posedge aclk); #1;
        checkOutput("rst_sready", {31'd0, s_ready}, 32'd1);
        checkOutput("rst_mvalid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_mlast",  {31'd0, m_last},  32'd0);
        checkOutput("rst_A", m_colorA, 32'd0);
        checkOutput("rst_B", m_colorB, 32'd0);
        checkOutput("rst_C", m_colorC, 32'd0);
        checkOutput("rst_D", m_colorD, 32'd0);
        m_ready = 1'b1;

        applyStimulus("alpha", 32'h80402010, 32'h11223344, 4'd6, 4'd7, 32'h10101010, 32'hEFEFEFEF);
        applyStimulus("sat30", 32'h112233C0, 32'h44556630, 4'd10, 4'd0, 32'hC0C0C0FF, 32'h00000000);
        applyStimulus("sat80", 32'h112233C0, 32'h44556680, 4'd10, 4'd0, 32'h7F7F7FFF, 32'h00000000);
        applyStimulus("zeroDst", 32'h12345678, 32'h00FF7F80, 4'd0, 4'd4, 32'h00000000, 32'h00FF7F80);
        applyStimulus("oneInvDst", 32'h12345678, 32'h00FF7F80, 4'd1, 4'd5, 32'hFFFFFFFF, 32'hFF00807F);
        applyStimulus("srcColor", 32'h12345678, 32'hA1B2C3D4, 4'd2, 4'd3, 32'h12345678, 32'hEDCBA987);
        applyStimulus("dstAlpha", 32'h12345678, 32'hA1B2C3D4, 4'd8, 4'd9, 32'hD4D4D4D4, 32'h2B2B2B2B);
        applyStimulus("rsvd1314", 32'h12345678, 32'hA1B2C3D4, 4'd13, 4'd14, 32'h00000000, 32'h00000000);
        applyStimulus("rsvd15", 32'h12345678, 32'hA1B2C3D4, 4'd15, 4'd15, 32'h00000000, 32'h00000000);

        constColor = 32'h0A0B0C0D;
`ifdef BLEND_CONSTANT_COLOR_EN
        expConst    = 32'h0A0B0C0D;
        expConstInv = 32'hF5F4F3F2;
`else
        expConst    = 32'h00000000;
        expConstInv = 32'h00000000;
`endif
        applyStimulus("constColor", 32'h12345678, 32'hA1B2C3D4, 4'd11, 4'd12, expConst, expConstInv);
        @(posedge aclk); #1;

        // Back-to-back stream with m_ready following 1,0,0,1
        readyPat = 4'b1001;
        idxIn    = 0;
        idxOut   = 0;
        held     = 1'b0;
        for (int cyc = 0; cyc < 200 && idxOut < 8; cyc++) begin
            @(posedge aclk); #1;
            if (held) begin
                checkOutput("holdA", m_colorA, heldA);
                checkOutput("holdB", m_colorB, heldB);
                checkOutput("holdC", m_colorC, heldC);
                checkOutput("holdLast", {31'd0, m_last}, {31'd0, heldLast});
            end
            m_ready     = readyPat[cyc % 4];
            s_valid     = (idxIn < 8);
            s_src       = 32'hA0000000 | idxIn;
            s_dst       = 32'h0B000000 | idxIn;
            s_srcFactor = 4'd1;
            s_dstFactor = 4'd0;
            s_last      = (idxIn == 7);
            #1;
            if (m_valid && !m_ready)
                checkOutput("stallReady", {31'd0, s_ready}, 32'd0);
            if (m_valid && m_ready) begin
                checkOutput("streamA", m_colorA, 32'hA0000000 | idxOut);
                checkOutput("streamC", m_colorC, 32'h0B000000 | idxOut);
                checkOutput("streamB", m_colorB, 32'hFFFFFFFF);
                checkOutput("streamLast", {31'd0, m_last}, (idxOut == 7) ? 32'd1 : 32'd0);
                idxOut++;
            end
            if (s_valid && s_ready)
                idxIn++;
            held     = m_valid && !m_ready;
            heldA    = m_colorA;
            heldB    = m_colorB;
            heldC    = m_colorC;
            heldLast = m_last;
        end
        checkOutput("streamCount", idxOut, 32'd8);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(posedge aclk); #1;
        checkOutput("noExtraBeat", {31'd0, m_valid}, 32'd0);

        // Reset with two beats in flight
        s_valid     = 1'b1;
        s_src       = 32'hDEADBEEF;
        s_dst       = 32'hCAFEF00D;
        s_srcFactor = 4'd1;
        s_dstFactor = 4'd1;
        s_last      = 1'b1;
        @(posedge aclk); #1;
        s_src = 32'h01234567;
        @(posedge aclk); #1;
        checkOutput("preRstValid", {31'd0, m_valid}, 32'd1);
        reset   = 1'b1;
        s_valid = 1'b0;
        @(posedge aclk); #1;
        checkOutput("midRstValid", {31'd0, m_valid}, 32'd0);
        checkOutput("midRstLast",  {31'd0, m_last},  32'd0);
        checkOutput("midRstA", m_colorA, 32'd0);
        checkOutput("midRstB", m_colorB, 32'd0);
        checkOutput("midRstC", m_colorC, 32'd0);
        checkOutput("midRstD", m_colorD, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk); #1;
            checkOutput("postRstValid", {31'd0, m_valid}, 32'd0);
            checkOutput("postRstReady", {31'd0, s_ready}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
